// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, issues word fetches under a credit
// limit, buffers in-order responses in a small FIFO and hands them to decode.
// A redirect restarts fetch, flushes the FIFO and discards in-flight responses.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_fifo_pc    [DEPTH];

  logic [SW-1:0] w_inflight;
  logic          w_has_credit;
  logic          w_accept;
  logic          w_push;
  logic          w_drop_resp;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;
  logic [CW-1:0] w_resp_one;
  logic          w_unused;

  assign w_unused      = ^redirect_pc[1:0];
  assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

  // Credits cover requests in flight (kept or to be dropped) plus buffered entries
  assign w_inflight   = SW'(r_outstanding) + SW'(r_drop) + SW'(r_count);
  assign w_has_credit = (w_inflight < SW'(DEPTH));

  // Gated by reset_n so the request line drops immediately on asynchronous reset
  assign imem_req_valid = reset_n && !redirect_valid && w_has_credit;
  assign imem_req_addr  = r_pc;
  assign w_accept       = imem_req_valid && imem_req_ready;

  assign w_drop_resp = imem_resp_valid && (r_drop != '0);
  assign w_push      = imem_resp_valid && (r_drop == '0) && !redirect_valid;
  assign w_resp_one  = {{(CW-1){1'b0}}, imem_resp_valid};

  assign id_valid = (r_count != '0);
  assign w_pop    = id_valid && id_ready && !redirect_valid;
  assign id_instr = id_valid ? r_fifo_instr[r_rptr] : '0;
  assign id_pc    = id_valid ? r_fifo_pc[r_rptr]    : '0;

  // Fetch PC and the PC tag for the next kept response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc      <= w_redirect_pc;
      r_resp_pc <= w_redirect_pc;
    end else begin
      if (w_accept) r_pc      <= r_pc + 32'd4;
      if (w_push)   r_resp_pc <= r_resp_pc + 32'd4;
    end
  end

  // In-flight request accounting: kept requests and responses still to discard
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
      r_drop        <= '0;
    end else if (redirect_valid) begin
      // A response in this cycle is discarded either way: it consumes an existing
      // drop or is one of the outstanding requests just converted to drops.
      r_outstanding <= '0;
      r_drop        <= r_drop + r_outstanding - w_resp_one;
    end else begin
      if (w_drop_resp) r_drop <= r_drop - CW'(1);
      case ({w_accept, w_push})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are only visible through a nonzero count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= imem_resp_data;
      r_fifo_pc[r_wptr]    <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage with an in-order memory model and a
// transaction-level reference of the fetch stream.
module tb_if_stage;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  if_stage #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned ep;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  req_t        memq[$];
  ent_t        fq[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  int unsigned epoch = 0;
  int unsigned n_acc = 0;
  logic [31:0] exp_pc = RPC;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  // One clock cycle, entered and left at posedge+1
  task automatic cycle(input bit rdy, input bit idr, input bit redir,
                       input logic [31:0] rpc, input int unsigned lmin,
                       input int unsigned lmax);
    logic        exp_rv;
    bit          acc;
    bit          pop;
    bit          resp;
    logic [31:0] addr_now;
    req_t        e;
    ent_t        h;
    imem_req_ready = rdy;
    id_ready       = idr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    resp           = (memq.size() != 0) && (memq[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? memword(memq[0].addr) : $urandom;
    #1;
    exp_rv = !redir && ((memq.size() + fq.size()) < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_pc);
    chk("id_valid", 32'(id_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk("id_pc", id_pc, fq[0].pc);
      chk("id_instr", id_instr, fq[0].instr);
    end else begin
      chk("id_pc_empty", id_pc, 32'h0);
      chk("id_instr_empty", id_instr, 32'h0);
    end
    acc      = imem_req_valid && rdy;
    addr_now = imem_req_addr;
    pop      = !redir && idr && (fq.size() != 0);
    @(posedge clk);
    cyc++;
    if (pop) void'(fq.pop_front());
    if (resp) begin
      e = memq.pop_front();
      if (!redir && e.ep == epoch) begin
        h.instr = memword(e.addr);
        h.pc    = e.addr;
        fq.push_back(h);
      end
    end
    if (redir) begin
      fq.delete();
      epoch++;
      exp_pc = {rpc[31:2], 2'b00};
    end else if (acc) begin
      exp_pc = exp_pc + 32'd4;
    end
    if (acc) begin
      e.addr = addr_now;
      e.due  = cyc - 1 + $urandom_range(lmax, lmin);
      e.ep   = epoch;
      memq.push_back(e);
      n_acc++;
    end
    #1;
    assert ((memq.size() + fq.size()) <= DEPTH)
      else $error("fetch credits exceeded: %0d in flight, %0d buffered", memq.size(), fq.size());
  endtask

  // Asynchronous reset pulse, entered and left at posedge+1
  task automatic do_reset();
    #1;
    reset_n         = 1'b0;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    memq.delete();
    fq.delete();
    exp_pc = RPC;
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    id_ready        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Streaming from reset with 1-cycle memory
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1);

    // Decode stalled: exactly DEPTH requests, then drain and resume
    do_reset();
    n_acc = 0;
    repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1, 1);
    chk("stall_reqs", n_acc, DEPTH);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1);

    // Two requests in flight at 3-cycle latency, then redirect to 0x2002
    do_reset();
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 32'h0, 3, 3);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_2002, 3, 3);
    repeat (10) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1);

    // Redirect coinciding with a response and a pop
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1);
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_3000, 1, 1);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1);

    // PC wrap with a stuttering memory
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1, 1);
    repeat (30) cycle(1'($urandom_range(1, 0)), 1'b1, 1'b0, 32'h0, 1, 2);

    // Back-to-back redirects with slow memory
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0, 2, 4);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, $urandom, 2, 4);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 32'h0, 2, 4);

    // Random traffic with occasional redirects and resets
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(2, 0) != 0),
            1'($urandom_range(19, 0) == 0), $urandom, 1, $urandom_range(4, 1));
      if ($urandom_range(299, 0) == 0) do_reset();
    end

    // Reset with a full FIFO, then restart from RESET_PC
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1, 1);
    chk("full_before_reset", 32'(fq.size()), DEPTH);
    do_reset();
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
